// File: rtl/sha256_stream_padder.sv
// SHA-256 message padder: packs big-endian input beats into 512-bit blocks, appends 0x80 and the 64-bit bit length.
// Latency: a block is presented the cycle after its completing beat is accepted; input stalls while any block is presented.
module sha256_stream_padder #(
    parameter int IN_BYTES = 4,
    parameter int LEN_W    = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [8*IN_BYTES-1:0]   in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_last,
    input  logic [3:0]              in_nbytes,
    output logic [511:0]            blk_data,
    output logic                    blk_valid,
    input  logic                    blk_ready,
    output logic                    blk_last
);

    localparam int BEATS = 64 / IN_BYTES;
    localparam int IDX_W = $clog2(BEATS);

    localparam logic [1:0] S_FILL      = 2'd0;
    localparam logic [1:0] S_EMIT      = 2'd1;
    localparam logic [1:0] S_EMIT_LAST = 2'd2;
    localparam logic [1:0] S_EXTRA     = 2'd3;

    logic [1:0]               state_q, state_d;
    logic [IDX_W-1:0]         beat_idx_q, beat_idx_d;
    logic [LEN_W-1:0]         len_q, len_d;
    logic [63:0][7:0]         buf_q, buf_d;
    logic                     extra_pend_q, extra_pend_d;
    logic                     extra_80_q, extra_80_d;

    logic [IN_BYTES-1:0][7:0] in_bytes;
    logic [3:0]               n_eff;
    logic [3:0]               n_wr;
    logic [6:0]               base;
    logic [6:0]               pos;
    logic [5:0]               k;

    always_comb begin
        state_d      = state_q;
        beat_idx_d   = beat_idx_q;
        len_d        = len_q;
        buf_d        = buf_q;
        extra_pend_d = extra_pend_q;
        extra_80_d   = extra_80_q;

        in_bytes = in_data;
        n_eff    = (in_nbytes > 4'(IN_BYTES)) ? 4'(IN_BYTES) : in_nbytes;
        n_wr     = in_last ? n_eff : 4'(IN_BYTES);
        base     = 7'(beat_idx_q) * 7'(IN_BYTES);
        // pos is the byte offset where the 0x80 terminator lands; 64 means it spills into an extra block
        pos      = base + 7'(n_wr);
        k        = '0;

        case (state_q)
            S_FILL: begin
                if (in_valid) begin
                    for (int b = 0; b < IN_BYTES; b++) begin
                        if (4'(b) < n_wr) begin
                            k = base[5:0] + 6'(b);
                            buf_d[6'd63 - k] = in_bytes[IN_BYTES-1-b];
                        end
                    end
                    len_d = len_q + LEN_W'({n_wr, 3'b000});
                    if (!in_last) begin
                        if (beat_idx_q == IDX_W'(BEATS-1)) begin
                            state_d      = S_EMIT;
                            beat_idx_d   = '0;
                            extra_pend_d = 1'b0;
                        end else begin
                            beat_idx_d = beat_idx_q + IDX_W'(1);
                        end
                    end else begin
                        beat_idx_d = '0;
                        if (pos < 7'd64) begin
                            buf_d[6'd63 - pos[5:0]] = 8'h80;
                        end
                        if (pos <= 7'd55) begin
                            buf_d[7:0] = 64'(len_d);
                            state_d    = S_EMIT_LAST;
                        end else begin
                            state_d      = S_EMIT;
                            extra_pend_d = 1'b1;
                            extra_80_d   = (pos == 7'd64);
                        end
                    end
                end
            end
            S_EMIT: begin
                if (blk_ready) begin
                    buf_d      = '0;
                    beat_idx_d = '0;
                    if (extra_pend_q) begin
                        // Trailer block: optional spilled terminator plus the length field
                        buf_d[63]    = extra_80_q ? 8'h80 : 8'h00;
                        buf_d[7:0]   = 64'(len_q);
                        extra_pend_d = 1'b0;
                        extra_80_d   = 1'b0;
                        state_d      = S_EXTRA;
                    end else begin
                        state_d = S_FILL;
                    end
                end
            end
            default: begin
                if (blk_ready) begin
                    buf_d      = '0;
                    beat_idx_d = '0;
                    len_d      = '0;
                    state_d    = S_FILL;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_FILL;
            beat_idx_q   <= '0;
            len_q        <= '0;
            buf_q        <= '0;
            extra_pend_q <= 1'b0;
            extra_80_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_idx_q   <= beat_idx_d;
            len_q        <= len_d;
            buf_q        <= buf_d;
            extra_pend_q <= extra_pend_d;
            extra_80_q   <= extra_80_d;
        end
    end

    assign in_ready  = (state_q == S_FILL);
    assign blk_valid = (state_q != S_FILL);
    assign blk_last  = (state_q == S_EMIT_LAST) || (state_q == S_EXTRA);
    assign blk_data  = buf_q;

endmodule

// File: tb/tb_sha256_stream_padder.sv
// Directed bench for sha256_stream_padder with IN_BYTES=4; inputs driven and outputs sampled on the falling edge.
module tb_sha256_stream_padder;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  in_data;
    logic         in_valid;
    logic         in_ready;
    logic         in_last;
    logic [3:0]   in_nbytes;
    logic [511:0] blk_data;
    logic         blk_valid;
    logic         blk_ready;
    logic         blk_last;

    int nvec = 0;
    int nerr = 0;
    logic [31:0]  ew [16];
    logic [511:0] exp_blk;

    always #5 clk = ~clk;

    sha256_stream_padder #(.IN_BYTES(4), .LEN_W(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .in_nbytes (in_nbytes),
        .blk_data  (blk_data),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_last  (blk_last)
    );

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clr_words();
        for (int i = 0; i < 16; i++) ew[i] = 32'h0;
    endtask

    function automatic logic [511:0] packw();
        logic [511:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[511-32*i -: 32] = ew[i];
        return r;
    endfunction

    task automatic send(input logic [31:0] d, input logic last, input logic [3:0] nb);
        in_data   = d;
        in_valid  = 1'b1;
        in_last   = last;
        in_nbytes = nb;
        check("in_rdy", {511'b0, in_ready}, 512'd1);
        @(negedge clk);
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_nbytes = 4'd0;
        in_data   = 32'h0;
    endtask

    task automatic take_block(input string tag, input logic last);
        logic [511:0] e;
        e = packw();
        check({tag, "_vld"},  {511'b0, blk_valid}, 512'd1);
        check({tag, "_dat"},  blk_data, e);
        check({tag, "_last"}, {511'b0, blk_last}, {511'b0, last});
        check({tag, "_irdy"}, {511'b0, in_ready}, 512'd0);
        blk_ready = 1'b1;
        @(negedge clk);
        blk_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_data = '0; in_valid = 1'b0; in_last = 1'b0;
        in_nbytes = '0; blk_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_vld",  {511'b0, blk_valid}, 512'd0);
        check("rst_last", {511'b0, blk_last},  512'd0);
        check("rst_irdy", {511'b0, in_ready},  512'd1);
        reset = 1'b0;
        @(negedge clk);
        check("idle_vld", {511'b0, blk_valid}, 512'd0);

        // Empty message
        send(32'h0, 1'b1, 4'd0);
        clr_words(); ew[0] = 32'h80000000;
        take_block("empty", 1'b1);

        // "abc"
        send(32'h61626300, 1'b1, 4'd3);
        clr_words(); ew[0] = 32'h61626380; ew[15] = 32'h00000018;
        take_block("abc", 1'b1);

        // "Hello, SHA-256!"
        send(32'h48656c6c, 1'b0, 4'd4);
        send(32'h6f2c2053, 1'b0, 4'd4);
        send(32'h48412d32, 1'b0, 4'd4);
        send(32'h35362100, 1'b1, 4'd3);
        clr_words();
        ew[0] = 32'h48656c6c; ew[1] = 32'h6f2c2053; ew[2] = 32'h48412d32;
        ew[3] = 32'h35362180; ew[15] = 32'h00000078;
        take_block("hello", 1'b1);

        // 56 bytes: terminator at byte 56, length spills to a trailer block
        for (int i = 0; i < 14; i++) send(32'hA0000000 + i, (i == 13), (i == 13) ? 4'd4 : 4'd0);
        clr_words();
        for (int i = 0; i < 14; i++) ew[i] = 32'hA0000000 + i;
        ew[14] = 32'h80000000;
        take_block("m56_b1", 1'b0);
        clr_words(); ew[15] = 32'h000001C0;
        take_block("m56_b2", 1'b1);

        // 64 bytes: terminator does not fit, moves to byte 0 of the trailer
        for (int i = 0; i < 16; i++) send(32'hB0000000 + i, (i == 15), 4'd4);
        clr_words();
        for (int i = 0; i < 16; i++) ew[i] = 32'hB0000000 + i;
        take_block("m64_b1", 1'b0);
        clr_words(); ew[0] = 32'h80000000; ew[15] = 32'h00000200;
        take_block("m64_b2", 1'b1);

        // Backpressure with a competing beat offered
        send(32'h61626300, 1'b1, 4'd3);
        clr_words(); ew[0] = 32'h61626380; ew[15] = 32'h00000018;
        exp_blk = packw();
        in_data = 32'hDEADBEEF; in_valid = 1'b1; in_last = 1'b1; in_nbytes = 4'd4;
        for (int c = 0; c < 5; c++) begin
            check("bp_dat",  blk_data, exp_blk);
            check("bp_last", {511'b0, blk_last}, 512'd1);
            check("bp_irdy", {511'b0, in_ready}, 512'd0);
            @(negedge clk);
        end
        in_valid = 1'b0; in_last = 1'b0; in_nbytes = 4'd0; in_data = 32'h0;
        take_block("bp", 1'b1);
        send(32'h61626300, 1'b1, 4'd3);
        take_block("bp_next", 1'b1);

        // Reset while a block is pending
        send(32'h61626300, 1'b1, 4'd3);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_emit_vld",  {511'b0, blk_valid}, 512'd0);
        check("rst_emit_irdy", {511'b0, in_ready},  512'd1);

        // Reset mid-message
        send(32'h11111111, 1'b0, 4'd4);
        send(32'h22222222, 1'b0, 4'd4);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_msg_vld", {511'b0, blk_valid}, 512'd0);
        send(32'h61626300, 1'b1, 4'd3);
        clr_words(); ew[0] = 32'h61626380; ew[15] = 32'h00000018;
        take_block("rst_abc", 1'b1);
        check("end_irdy", {511'b0, in_ready}, 512'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
